// File: rtl/exec_sequencer.sv
// exec_sequencer: run controller for the 9-bit core; sequences IDLE/INIT/RUN/DONE,
// counts run cycles and arbitrates the data memory between host and core.
module exec_sequencer #(
    parameter int D       = 12,
    parameter int AW      = 8,
    parameter int DW      = 8,
    parameter int END_PC  = 128,
    parameter int TIMEOUT = 4096
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic [D-1:0]  prog_ctr,
    output logic          pc_rst,
    output logic          cpu_en,
    output logic          done,
    output logic          timeout,
    output logic [15:0]   cycle_cnt,
    output logic          host_gnt,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdat,
    output logic [DW-1:0] host_rdat,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdat,
    output logic [DW-1:0] cpu_rdat,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdat,
    input  logic [DW-1:0] mem_rdat
);
    typedef enum logic [1:0] {IDLE, INIT, RUN, DONE} state_t;

    state_t      state_q, state_d;
    logic        req_q;
    logic        done_q, done_d, timeout_q, timeout_d;
    logic [15:0] cnt_q, cnt_d;
    logic        pc_rst_q, pc_rst_d, cpu_en_q, cpu_en_d, host_gnt_q, host_gnt_d;
    logic        start;

    assign start = req & ~req_q;

    always_comb begin
        state_d   = state_q;
        done_d    = done_q;
        timeout_d = timeout_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE, DONE: if (start) begin
                state_d   = INIT;
                done_d    = 1'b0;
                timeout_d = 1'b0;
                cnt_d     = '0;
            end
            INIT: state_d = RUN;
            RUN: begin
                cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
                // completion beats the budget when both land in the same cycle
                if (prog_ctr == D'(END_PC)) begin
                    state_d   = DONE;
                    done_d    = 1'b1;
                    timeout_d = 1'b0;
                end else if (cnt_q == 16'(TIMEOUT - 1)) begin
                    state_d   = DONE;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        pc_rst_d   = (state_d == IDLE) || (state_d == INIT);
        cpu_en_d   = (state_d == RUN);
        host_gnt_d = (state_d == IDLE) || (state_d == DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            cnt_q      <= '0;
            pc_rst_q   <= 1'b1;
            cpu_en_q   <= 1'b0;
            host_gnt_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            req_q      <= req;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
            cnt_q      <= cnt_d;
            pc_rst_q   <= pc_rst_d;
            cpu_en_q   <= cpu_en_d;
            host_gnt_q <= host_gnt_d;
        end
    end

    assign pc_rst    = pc_rst_q;
    assign cpu_en    = cpu_en_q;
    assign done      = done_q;
    assign timeout   = timeout_q;
    assign cycle_cnt = cnt_q;
    assign host_gnt  = host_gnt_q;

    assign mem_we    = host_gnt_q ? host_we   : (cpu_en_q & cpu_we);
    assign mem_addr  = host_gnt_q ? host_addr : cpu_addr;
    assign mem_wdat  = host_gnt_q ? host_wdat : cpu_wdat;
    assign host_rdat = host_gnt_q ? mem_rdat  : '0;
    assign cpu_rdat  = host_gnt_q ? '0        : mem_rdat;
endmodule

// File: tb/tb_exec_sequencer.sv
// tb_exec_sequencer: directed stimulus with a scoreboard of expected run completions,
// checked by a monitor whenever done rises.
module tb_exec_sequencer;
    logic        clk, reset, req;
    logic [11:0] prog_ctr;
    logic        pc_rst, cpu_en, done, timeout, host_gnt;
    logic [15:0] cycle_cnt;
    logic        host_we, cpu_we, mem_we;
    logic [7:0]  host_addr, host_wdat, host_rdat, cpu_addr, cpu_wdat, cpu_rdat;
    logic [7:0]  mem_addr, mem_wdat, mem_rdat;

    exec_sequencer #(.D(12), .AW(8), .DW(8), .END_PC(128), .TIMEOUT(64)) dut (
        .clk(clk), .reset(reset), .req(req), .prog_ctr(prog_ctr),
        .pc_rst(pc_rst), .cpu_en(cpu_en), .done(done), .timeout(timeout),
        .cycle_cnt(cycle_cnt), .host_gnt(host_gnt),
        .host_we(host_we), .host_addr(host_addr), .host_wdat(host_wdat), .host_rdat(host_rdat),
        .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdat(cpu_wdat), .cpu_rdat(cpu_rdat),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdat(mem_wdat), .mem_rdat(mem_rdat)
    );

    typedef struct {
        logic        to;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    logic done_prev = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // scoreboard monitor: every rising done consumes one expected completion
    always @(negedge clk) begin
        if (done && !done_prev) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 expected no completion");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("done_timeout", 32'(timeout), 32'(e.to));
                chk("done_cycle_cnt", 32'(cycle_cnt), 32'(e.cnt));
                chk("done_cpu_en", 32'(cpu_en), 32'd0);
                chk("done_host_gnt", 32'(host_gnt), 32'd1);
                chk("done_pc_rst", 32'(pc_rst), 32'd0);
            end
        end
        done_prev = done;
    end

    task automatic start_run();
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        chk("init_pc_rst", 32'(pc_rst), 32'd1);
        chk("init_host_gnt", 32'(host_gnt), 32'd0);
        chk("init_cpu_en", 32'(cpu_en), 32'd0);
        chk("init_done", 32'(done), 32'd0);
        chk("init_cycle_cnt", 32'(cycle_cnt), 32'd0);
        @(negedge clk);
        chk("run_cpu_en", 32'(cpu_en), 32'd1);
        chk("run_pc_rst", 32'(pc_rst), 32'd0);
    endtask

    task automatic run_cycles(input int n, input int end_k);
        for (int k = 1; k <= n; k++) begin
            prog_ctr = (k == end_k) ? 12'd128 : 12'd5;
            @(negedge clk);
        end
        prog_ctr = 12'd5;
    endtask

    initial begin
        reset = 1'b0; req = 1'b0; prog_ctr = 12'd5;
        host_we = 1'b0; host_addr = '0; host_wdat = '0;
        cpu_we = 1'b0; cpu_addr = '0; cpu_wdat = '0; mem_rdat = 8'h3C;
        @(negedge clk);
        @(negedge clk);
        chk("rst_pc_rst", 32'(pc_rst), 32'd1);
        chk("rst_cpu_en", 32'(cpu_en), 32'd0);
        chk("rst_host_gnt", 32'(host_gnt), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        chk("rst_cycle_cnt", 32'(cycle_cnt), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        // host owns memory in IDLE; core write must not reach the bus
        host_we = 1'b1; host_addr = 8'h10; host_wdat = 8'h5A;
        cpu_we = 1'b1; cpu_addr = 8'h22; cpu_wdat = 8'hA5;
        #1;
        chk("idle_mem_we", 32'(mem_we), 32'd1);
        chk("idle_mem_addr", 32'(mem_addr), 32'h10);
        chk("idle_mem_wdat", 32'(mem_wdat), 32'h5A);
        chk("idle_host_rdat", 32'(host_rdat), 32'h3C);
        chk("idle_cpu_rdat", 32'(cpu_rdat), 32'h00);
        host_we = 1'b0; cpu_we = 1'b0;
        @(negedge clk);
        chk("idle_hold", 32'(pc_rst), 32'd1);

        // normal completion at RUN cycle 40, core drives the bus meanwhile
        exp_q.push_back('{to: 1'b0, cnt: 16'd40});
        start_run();
        host_we = 1'b1; cpu_we = 1'b1;
        #1;
        chk("run_mem_we", 32'(mem_we), 32'd1);
        chk("run_mem_addr", 32'(mem_addr), 32'h22);
        chk("run_mem_wdat", 32'(mem_wdat), 32'hA5);
        chk("run_host_rdat", 32'(host_rdat), 32'h00);
        chk("run_cpu_rdat", 32'(cpu_rdat), 32'h3C);
        cpu_we = 1'b0;
        #1;
        chk("run_host_we_dropped", 32'(mem_we), 32'd0);
        host_we = 1'b0;
        run_cycles(40, 40);
        chk("t2_done", 32'(done), 32'd1);

        // budget exhaustion with PC stuck
        exp_q.push_back('{to: 1'b1, cnt: 16'd64});
        start_run();
        run_cycles(64, 0);
        chk("t3_done", 32'(done), 32'd1);
        @(negedge clk);
        chk("t3_cnt_held", 32'(cycle_cnt), 32'd64);

        // END_PC on the last budget cycle wins; req rises mid-run and stays high
        exp_q.push_back('{to: 1'b0, cnt: 16'd64});
        start_run();
        req = 1'b1;
        run_cycles(64, 64);
        chk("t6_done", 32'(done), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4_hold_done", 32'(done), 32'd1);
            chk("t4_hold_pc_rst", 32'(pc_rst), 32'd0);
            chk("t4_hold_cnt", 32'(cycle_cnt), 32'd64);
        end
        req = 1'b0;
        @(negedge clk);
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        chk("t4_restart_done", 32'(done), 32'd0);
        chk("t4_restart_cnt", 32'(cycle_cnt), 32'd0);
        chk("t4_restart_pc_rst", 32'(pc_rst), 32'd1);
        chk("t4_restart_gnt", 32'(host_gnt), 32'd0);

        // asynchronous reset in RUN cycle 10
        @(negedge clk);
        run_cycles(9, 0);
        chk("t5_running", 32'(cpu_en), 32'd1);
        chk("t5_cnt", 32'(cycle_cnt), 32'd9);
        #1 reset = 1'b0;
        #1;
        chk("t5_cpu_en", 32'(cpu_en), 32'd0);
        chk("t5_host_gnt", 32'(host_gnt), 32'd1);
        chk("t5_pc_rst", 32'(pc_rst), 32'd1);
        chk("t5_done", 32'(done), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("t5_idle_after", 32'(host_gnt), 32'd1);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
